capture_sequencer: RTL

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms, triggers a storage write, then drains BYTE_COUNT bytes to a serial transmitter.
// Optional capture timeout is enabled by defining CAPTURE_TIMEOUT_EN.
module capture_sequencer #(
   parameter logic [15:0] BYTE_COUNT     = 16'd1024,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Arm,
   input  logic       Trigger,
   input  logic       Abort,
   input  logic       DataReadyToSend,
   input  logic       DataValid,
   input  logic [7:0] DataOut,
   input  logic       TxBusy,
   output logic       WriteStrobe,
   output logic       ReadEnable,
   output logic [7:0] TxData,
   output logic       TxStart,
   output logic [2:0] State,
   output logic       Done,
   output logic       Error
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      CAPTURE = 3'd2,
      RD_REQ  = 3'd3,
      RD_WAIT = 3'd4,
      TX_SEND = 3'd5,
      TX_WAIT = 3'd6,
      DONE    = 3'd7
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] cnt_inc_c;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        write_strobe_q, write_strobe_d;
   logic        read_enable_q, read_enable_d;
   logic        tx_start_q, tx_start_d;
   logic        done_q, done_d;
   logic        tx_wait_seen_q, tx_wait_seen_d;
`ifdef CAPTURE_TIMEOUT_EN
   logic [23:0] tmo_q, tmo_d;
   logic        error_q, error_d;
`endif

   assign cnt_inc_c = 16'(cnt_q + 16'd1);

   // Next-state and registered-output logic; every pulse is set on the transition into its state.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      tx_data_d      = tx_data_q;
      write_strobe_d = 1'b0;
      read_enable_d  = 1'b0;
      tx_start_d     = 1'b0;
      done_d         = 1'b0;
      tx_wait_seen_d = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      tmo_d          = tmo_q;
      error_d        = error_q;
`endif

      case (state_q)
         IDLE: begin
            if (Arm) begin
               state_d = ARMED;
`ifdef CAPTURE_TIMEOUT_EN
               error_d = 1'b0;
`endif
            end
         end
         ARMED: begin
            if (Trigger) begin
               state_d        = CAPTURE;
               cnt_d          = 16'd0;
               write_strobe_d = 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
               tmo_d          = 24'd0;
`endif
            end
         end
         CAPTURE: begin
            if (DataReadyToSend) begin
               state_d       = RD_REQ;
               read_enable_d = 1'b1;
            end
`ifdef CAPTURE_TIMEOUT_EN
            else if (tmo_q == 24'(TIMEOUT_CYCLES - 24'd1)) begin
               state_d = IDLE;
               error_d = 1'b1;
            end else begin
               tmo_d = 24'(tmo_q + 24'd1);
            end
`endif
         end
         RD_REQ: state_d = RD_WAIT;
         RD_WAIT: begin
            if (DataValid) begin
               tx_data_d = DataOut;
               state_d   = TX_SEND;
            end
         end
         TX_SEND: begin
            if (!TxBusy) begin
               tx_start_d = 1'b1;
               state_d    = TX_WAIT;
            end
         end
         TX_WAIT: begin
            // First TX_WAIT cycle is skipped so the transmitter has time to raise TxBusy.
            tx_wait_seen_d = 1'b1;
            if (tx_wait_seen_q && !TxBusy) begin
               cnt_d = cnt_inc_c;
               if (cnt_inc_c == BYTE_COUNT) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d       = RD_REQ;
                  read_enable_d = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (Abort) begin
         state_d        = IDLE;
         cnt_d          = 16'd0;
         tx_data_d      = tx_data_q;
         write_strobe_d = 1'b0;
         read_enable_d  = 1'b0;
         tx_start_d     = 1'b0;
         done_d         = 1'b0;
         tx_wait_seen_d = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q        <= IDLE;
         cnt_q          <= 16'd0;
         tx_data_q      <= 8'h00;
         write_strobe_q <= 1'b0;
         read_enable_q  <= 1'b0;
         tx_start_q     <= 1'b0;
         done_q         <= 1'b0;
         tx_wait_seen_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tx_data_q      <= tx_data_d;
         write_strobe_q <= write_strobe_d;
         read_enable_q  <= read_enable_d;
         tx_start_q     <= tx_start_d;
         done_q         <= done_d;
         tx_wait_seen_q <= tx_wait_seen_d;
      end
   end

`ifdef CAPTURE_TIMEOUT_EN
   always_ff @(posedge Clock) begin
      if (Reset) begin
         tmo_q   <= 24'd0;
         error_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         error_q <= error_d;
      end
   end

   assign Error = error_q;
`else
   // Timeout parameter only matters when the timeout feature is built; Error is constant 0.
   assign Error = 1'b0 & (TIMEOUT_CYCLES != 24'd0);
`endif

   assign State       = state_q;
   assign WriteStrobe = write_strobe_q;
   assign ReadEnable  = read_enable_q;
   assign TxData      = tx_data_q;
   assign TxStart     = tx_start_q;
   assign Done        = done_q;

endmodule
